// File: rtl/product_accumulator_if.sv
// Bundle of signals between the Booth multiplier, the product accumulator
// and the downstream result consumer. The accumulator sits on the slave side.
interface product_accumulator_if #(
  parameter int MUL_WIDTH = 4,
  parameter int ACC_LEN   = 4,
  parameter int ACC_WIDTH = 2*MUL_WIDTH+2
);
  localparam int CW = $clog2(ACC_LEN)+1;

  logic                   ready_bit;
  logic [2*MUL_WIDTH-1:0] product;
  logic                   clear;
  logic                   prod_stall;
  logic [CW-1:0]          acc_count;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic                   acc_sat;
  logic                   acc_valid;
  logic                   acc_ready;
  logic                   acc_err;

  modport master (
    output ready_bit, product, clear, acc_ready,
    input  prod_stall, acc_count, acc_sum, acc_sat, acc_valid, acc_err
  );

  modport slave (
    input  ready_bit, product, clear, acc_ready,
    output prod_stall, acc_count, acc_sum, acc_sat, acc_valid, acc_err
  );
endinterface

// File: rtl/product_accumulator.sv
// Captures each product from the sequential multiplier on the rising edge of
// its ready level, sums groups of ACC_LEN products with signed saturation and
// hands each group result downstream over a one-deep valid/ready buffer.
module product_accumulator #(
  parameter int MUL_WIDTH = 4,
  parameter int ACC_LEN   = 4,
  parameter int ACC_WIDTH = 2*MUL_WIDTH+2
) (
  input  logic                   clk,
  input  logic                   rst,
  product_accumulator_if.slave   bus
);
  localparam int PW = 2*MUL_WIDTH;
  localparam int CW = $clog2(ACC_LEN)+1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN-1);

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e                       state_q, state_d;
  logic                         ready_q;
  logic signed [ACC_WIDTH-1:0]  psum_q, psum_d;
  logic                         psat_q, psat_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]  sum_q, sum_d;
  logic                         sat_q, sat_d;
  logic                         err_q, err_d;
  logic                         stall_q, stall_d;

  logic                         capture, consume, complete, overflow, load;
  logic signed [ACC_WIDTH-1:0]  base_sum;
  logic                         base_sat;
  logic [CW-1:0]                base_cnt;
  logic signed [ACC_WIDTH:0]    sum_wide;
  logic signed [ACC_WIDTH-1:0]  sum_clamped;
  logic                         clamp_hit;

  // True when the one-bit-wider sum does not fit back into ACC_WIDTH bits.
  function automatic logic ovf_fn(input logic signed [ACC_WIDTH:0] v);
    return v[ACC_WIDTH] != v[ACC_WIDTH-1];
  endfunction

  // Clamp the one-bit-wider sum to the signed ACC_WIDTH range.
  function automatic logic signed [ACC_WIDTH-1:0] sat_fn(input logic signed [ACC_WIDTH:0] v);
    if (ovf_fn(v))
      return v[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return v[ACC_WIDTH-1:0];
  endfunction

  // Next-state decode: capture edge, clear, saturating add, completion and overflow.
  always_comb begin
    capture  = bus.ready_bit & ~ready_q;
    consume  = (state_q == HOLD) & bus.acc_ready;
    // Clear applies before the capture so a product arriving with clear starts a new group.
    base_sum = bus.clear ? '0 : psum_q;
    base_sat = bus.clear ? 1'b0 : psat_q;
    base_cnt = bus.clear ? '0 : cnt_q;
    sum_wide = {base_sum[ACC_WIDTH-1], base_sum}
             + {{(ACC_WIDTH+1-PW){bus.product[PW-1]}}, bus.product};
    sum_clamped = sat_fn(sum_wide);
    clamp_hit   = ovf_fn(sum_wide);
    complete = capture & (base_cnt == LAST);
    overflow = complete & (state_q == HOLD) & ~consume;
    load     = complete & ~overflow;

    psum_d = base_sum;
    psat_d = base_sat;
    cnt_d  = base_cnt;
    if (capture && !complete) begin
      psum_d = sum_clamped;
      psat_d = base_sat | clamp_hit;
      cnt_d  = base_cnt + CW'(1);
    end else if (load) begin
      psum_d = '0;
      psat_d = 1'b0;
      cnt_d  = '0;
    end

    // A dropped product leaves the partial group untouched and only flags the error.
    sum_d   = load ? sum_clamped : sum_q;
    sat_d   = load ? (base_sat | clamp_hit) : sat_q;
    err_d   = err_q | overflow;
    state_d = state_q;
    if (load)         state_d = HOLD;
    else if (consume) state_d = EMPTY;
    stall_d = (cnt_d == LAST) && (state_d == HOLD);
  end

  // State, partial group and held result registers; idle-high ready_bit is masked after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      psum_q  <= '0;
      psat_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= bus.ready_bit;
      psum_q  <= psum_d;
      psat_q  <= psat_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign bus.acc_valid  = (state_q == HOLD);
  assign bus.acc_sum    = sum_q;
  assign bus.acc_sat    = sat_q;
  assign bus.acc_count  = cnt_q;
  assign bus.acc_err    = err_q;
  assign bus.prod_stall = stall_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Drives a default-width accumulator and an 8-bit-accumulator variant with the
// same product stream; a reference model built on plain integer sums and
// queues predicts every group result and the per-cycle status outputs.
module tb_product_accumulator;
  localparam int MW = 4;
  localparam int AL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rb  = 1'b1;
  logic [7:0] pr  = '0;
  logic       clr = 1'b0;
  logic       rdy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.MUL_WIDTH(MW), .ACC_LEN(AL))                 if0 ();
  product_accumulator_if #(.MUL_WIDTH(MW), .ACC_LEN(AL), .ACC_WIDTH(8)) if1 ();

  assign if0.ready_bit = rb;  assign if1.ready_bit = rb;
  assign if0.product   = pr;  assign if1.product   = pr;
  assign if0.clear     = clr; assign if1.clear     = clr;
  assign if0.acc_ready = rdy; assign if1.acc_ready = rdy;

  product_accumulator #(.MUL_WIDTH(MW), .ACC_LEN(AL))                 dut0 (.clk(clk), .rst(rst), .bus(if0));
  product_accumulator #(.MUL_WIDTH(MW), .ACC_LEN(AL), .ACC_WIDTH(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Per-instance views of the DUT outputs.
  int   d_cnt [2];
  int   d_sum [2];
  logic d_valid [2], d_sat [2], d_stall [2], d_err [2];
  always_comb begin
    d_cnt[0] = int'(if0.acc_count);  d_cnt[1] = int'(if1.acc_count);
    d_sum[0] = int'($signed(if0.acc_sum)); d_sum[1] = int'($signed(if1.acc_sum));
    d_valid[0] = if0.acc_valid; d_valid[1] = if1.acc_valid;
    d_sat[0] = if0.acc_sat;     d_sat[1] = if1.acc_sat;
    d_stall[0] = if0.prod_stall; d_stall[1] = if1.prod_stall;
    d_err[0] = if0.acc_err;     d_err[1] = if1.acc_err;
  end

  // Reference model state.
  int W [2] = '{2*MW+2, 8};
  int grp [2][$];
  int q_sum [2][$];
  bit q_sat [2][$];
  bit m_valid [2] = '{0, 0};
  bit m_err [2]   = '{0, 0};
  bit prev_rb = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Saturating running sum over a whole group of products.
  function automatic void fold(input int q[$], input int w, output int s, output bit sat);
    longint mx = (longint'(1) << (w-1)) - 1;
    longint mn = -(longint'(1) << (w-1));
    longint t;
    s = 0; sat = 0;
    foreach (q[k]) begin
      t = longint'(s) + longint'(q[k]);
      if (t > mx) begin t = mx; sat = 1; end
      else if (t < mn) begin t = mn; sat = 1; end
      s = int'(t);
    end
  endfunction

  function automatic void model_step(input int i);
    bit cap = rb && !prev_rb;
    bit v = m_valid[i];
    bit cons = v && rdy;
    int s; bit sat; int tmp[$];
    if (clr) grp[i].delete();
    if (cons) m_valid[i] = 0;
    if (cap) begin
      if (grp[i].size() == AL-1) begin
        if (v && !cons) m_err[i] = 1;
        else begin
          tmp = grp[i];
          tmp.push_back(int'($signed(pr)));
          fold(tmp, W[i], s, sat);
          q_sum[i].push_back(s);
          q_sat[i].push_back(sat);
          m_valid[i] = 1;
          grp[i].delete();
        end
      end else grp[i].push_back(int'($signed(pr)));
    end
  endfunction

  // Monitor: compare status outputs, pop results on handshake, then advance the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        grp[i].delete(); q_sum[i].delete(); q_sat[i].delete();
        m_valid[i] = 0; m_err[i] = 0;
      end
      prev_rb = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("count%0d", i), d_cnt[i], grp[i].size());
        chk($sformatf("valid%0d", i), int'(d_valid[i]), int'(m_valid[i]));
        chk($sformatf("stall%0d", i), int'(d_stall[i]),
            int'(grp[i].size() == AL-1 && m_valid[i]));
        chk($sformatf("err%0d", i), int'(d_err[i]), int'(m_err[i]));
        if (d_valid[i] && rdy) begin
          if (q_sum[i].size() == 0) chk($sformatf("unexpected_result%0d", i), 1, 0);
          else begin
            chk($sformatf("sum%0d", i), d_sum[i], q_sum[i].pop_front());
            chk($sformatf("sat%0d", i), int'(d_sat[i]), int'(q_sat[i].pop_front()));
          end
        end
        model_step(i);
      end
      prev_rb = rb;
    end
  end

  task automatic step(input logic b, input int p, input logic c, input logic r);
    rb = b; pr = 8'(p); clr = c; rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int p, input logic r);
    step(1'b0, 0, 1'b0, r);
    step(1'b1, p, 1'b0, r);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_sum%0d", i), d_sum[i], 0);
      chk($sformatf("rst_sat%0d", i), int'(d_sat[i]), 0);
      chk($sformatf("rst_valid%0d", i), int'(d_valid[i]), 0);
      chk($sformatf("rst_count%0d", i), d_cnt[i], 0);
      chk($sformatf("rst_stall%0d", i), int'(d_stall[i]), 0);
      chk($sformatf("rst_err%0d", i), int'(d_err[i]), 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    // Idle-high ready_bit across reset release must not be captured.
    rb = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 0, 1'b0, 1'b0);
    chk("idle_count", d_cnt[0], 0);
    chk("idle_valid", int'(d_valid[0]), 0);

    // Mixed-sign group; second group saturates only in the 8-bit variant.
    pulse(6, 1); pulse(-15, 1); pulse(64, 1); pulse(-56, 1);
    pulse(64, 1); pulse(64, 1); pulse(64, 1); pulse(-8, 1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Held result, stall, and a dropped product.
    for (int k = 0; k < 7; k++) pulse(1, 0);
    chk("held_sum", d_sum[0], 4);
    chk("stall_after7", int'(d_stall[0]), 1);
    pulse(1, 0);
    chk("drop_err", int'(d_err[0]), 1);
    chk("drop_count", d_cnt[0], 3);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("drain_valid", int'(d_valid[0]), 0);
    chk("drain_stall", int'(d_stall[0]), 0);

    // Completion on the same edge as a consume keeps acc_valid high.
    pulse(2, 0);
    pulse(1, 0); pulse(1, 0); pulse(1, 0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 3, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("b2b_valid", int'(d_valid[0]), 1);
    chk("b2b_sum", d_sum[0], 6);
    step(1'b0, 0, 1'b0, 1'b1);

    // Clear together with a capture starts a new group.
    pulse(3, 1); pulse(5, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 7, 1'b1, 1'b1);
    chk("clear_count", d_cnt[0], 1);
    pulse(1, 1); pulse(1, 1); pulse(1, 1);
    step(1'b0, 0, 1'b0, 1'b1);

    // Asynchronous reset while a result is held and a group is partial.
    for (int k = 0; k < 5; k++) pulse(k == 4 ? 2 : 1, 0);
    do_reset();

    // Randomised traffic with wide products to exercise saturation.
    for (int k = 0; k < 600; k++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
    for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("queue0_empty", q_sum[0].size(), 0);
    chk("queue1_empty", q_sum[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
